regfile_wb_queue: RTL and testbench
===================================

# regfile_wb_queue

Write-side front end for the 32×32 register file. Accepts register writeback requests from two producers: the ALU pipeline stage and the long-latency load/mul-div unit. Buffers them in a small in-order queue and drains one per cycle onto the register file's single write port (`reg_write` / `write_reg_num` / `write_data`). Also gives decode a pending-write scoreboard with youngest-match forwarding, so readers of the register file can stall or bypass.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, at least 2.
- `DATA_W`, 32: register data width.
- `ADDR_W`, 5: register index width.

Ports:
- `clk`, in, 1: single clock, rising-edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `src0_valid` / `src0_ready`, in / out, 1 / 1: ALU writeback handshake.
- `src0_rd` / `src0_data`, in, ADDR_W / DATA_W: ALU destination register and value.
- `src1_valid` / `src1_ready`, in / out, 1 / 1: load/mul-div writeback handshake.
- `src1_rd` / `src1_data`, in, ADDR_W / DATA_W: load/mul-div destination register and value.
- `wb_hold`, in, 1: write port borrowed elsewhere; inhibits draining.
- `reg_write`, out, 1: register file write enable.
- `write_reg_num`, out, ADDR_W: register file write index.
- `write_data`, out, DATA_W: register file write value.
- `chk_rs1` / `chk_rs2`, in, ADDR_W: decode source registers to check.
- `rs1_pending` / `rs2_pending`, out, 1: a queued write targets that register.
- `rs1_fwd` / `rs2_fwd`, out, DATA_W: data of the youngest matching entry; 0 if no match.
- `count`, out, clog2(DEPTH)+1: current occupancy.

## Operation
- Handshake: a transfer occurs on a rising edge when valid && ready. Producers hold rd/data stable while valid && !ready.
- At most one enqueue per cycle. src0 has fixed priority over src1.
  - `src0_ready` = `reset` && !full.
  - `src1_ready` = `reset` && !full && !`src0_valid`.
- A transfer with rd == 0 is accepted and discarded. It is never stored, so x0 is never written.
- Drain: when the queue is not empty and `wb_hold` is low:
  - `reg_write` = 1, `write_reg_num`/`write_data` = head entry.
  - The head pops on the same edge.
- When empty or held: `reg_write` = 0, and `write_reg_num`/`write_data` = 0.
- Full is decided from the registered `count` only. At `count` == DEPTH, both ready outputs stay low even if a pop happens that cycle.
- Simultaneous push and pop when not full: `count` is unchanged, and the head advances while the tail writes.
- Scoreboard:
  - `rsN_pending` = `chk_rsN` != 0 && some valid entry has rd == `chk_rsN`. The head entry being drained this cycle counts.
  - `rsN_fwd` takes the value from the youngest such entry (nearest the tail).
  - These outputs are purely combinational from the stored entries and `chk_rsN`.
- Ordering: entries drain strictly in acceptance order. Two writes to the same rd land in producer order.
- Pointers are ADDR of clog2(DEPTH) bits and wrap modulo DEPTH. `count` is kept separately, so full and empty are unambiguous.

## Timing
- Reset (asynchronous, `reset` low), all outputs: `count` = 0, `reg_write` = 0, `write_reg_num` = 0, `write_data` = 0, both ready = 0, both pending = 0, both fwd = 0. Pointers clear to 0.
- Reset asserted mid-operation discards all queued entries immediately. No further write is issued.
- After release: ready = 1 combinationally, and the first accept is possible on the next edge.
- Latency: accepted at edge N, `reg_write` is high throughout cycle N+1, and the register file captures at edge N+1 (given `wb_hold` = 0). There is no same-cycle bypass from source to write port.
- Pending/fwd reflect an entry starting the cycle after its acceptance, through the cycle it drains.
- Sustained throughput: one write per cycle.

## Structure
- Shared package `wb_pkg`: `DEPTH`, `DATA_W`, `ADDR_W`, and a struct `wb_entry_t` {rd, data}.
- Sub-module `wb_fifo`: parametric storage, pointers, and count, with push/pop/full/empty and a flat view of the entries.
- Top level holds the source arbitration, x0 filter, drain gating, and the youngest-match scoreboard (priority search from tail toward head).

## Test plan
- Reset, then src0 writes rd=5, data=0xDEAD_BEEF → next cycle `reg_write`=1, `write_reg_num`=5, `write_data`=0xDEADBEEF; `count` returns to 0.
- src0 and src1 both valid (rd 3 / rd 7) → src1_ready=0; rd 3 enqueued first; src1 held and accepted the following cycle; writes issue in order 3 then 7.
- `wb_hold`=1 with 4 pushes → `count`=4 and both ready=0; 5th request stalls; release hold → 4 writes on consecutive cycles, and ready rises after the first pop.
- Queue holds rd 9=0x11 then rd 9=0x22, `chk_rs1`=9 → `rs1_pending`=1, `rs1_fwd`=0x22; `chk_rs2`=0 → `rs2_pending`=0.
- src1 rd=0, data=0x5 → accepted, `count` stays 0, `reg_write` never asserts.
- Assert `reset` low with 3 queued entries → outputs zero immediately; after release, no stale `reg_write`.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared sizing and entry layout for the register-file writeback queue.
package wb_pkg;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// In-order entry storage with wrapping pointers and a separate occupancy count.
module wb_fifo #(
  parameter  int DEPTH = wb_pkg::DEPTH,
  parameter  int WIDTH = $bits(wb_pkg::wb_entry_t),
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_entry,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [WIDTH-1:0]       head_entry,
  output logic [PTR_W-1:0]       tail_ptr,
  output logic [CNT_W-1:0]       count,
  output logic [DEPTH*WIDTH-1:0] entries
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic             do_push;
  logic             do_pop;

  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);
  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign head_entry = mem[head_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (do_push) tail_ptr <= tail_ptr + 1'b1;
      if (do_pop)  head_ptr <= head_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload is qualified by count/pointers, so it carries no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[tail_ptr] <= push_entry;
  end

  always_comb begin
    entries = '0;
    for (int i = 0; i < DEPTH; i++) entries[i*WIDTH +: WIDTH] = mem[i];
  end
endmodule

// File: rtl/regfile_wb_queue.sv
// Two-producer writeback queue feeding the register file write port, with a
// pending-write scoreboard that forwards the youngest queued value.
module regfile_wb_queue #(
  parameter  int DEPTH  = wb_pkg::DEPTH,
  parameter  int DATA_W = wb_pkg::DATA_W,
  parameter  int ADDR_W = wb_pkg::ADDR_W,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              src0_valid,
  output logic              src0_ready,
  input  logic [ADDR_W-1:0] src0_rd,
  input  logic [DATA_W-1:0] src0_data,
  input  logic              src1_valid,
  output logic              src1_ready,
  input  logic [ADDR_W-1:0] src1_rd,
  input  logic [DATA_W-1:0] src1_data,
  input  logic              wb_hold,
  output logic              reg_write,
  output logic [ADDR_W-1:0] write_reg_num,
  output logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] chk_rs1,
  input  logic [ADDR_W-1:0] chk_rs2,
  output logic              rs1_pending,
  output logic              rs2_pending,
  output logic [DATA_W-1:0] rs1_fwd,
  output logic [DATA_W-1:0] rs2_fwd,
  output logic [CNT_W-1:0]  count
);
  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);
  localparam int PTR_W   = $clog2(DEPTH);

  logic                     full;
  logic                     empty;
  logic                     acc0;
  logic                     acc1;
  logic                     push;
  logic                     drain;
  entry_t                   push_entry;
  entry_t                   head_entry;
  logic [PTR_W-1:0]         tail_ptr;
  logic [DEPTH*ENTRY_W-1:0] entries;

  // Walk from the newest entry back toward the head; first hit is the youngest.
  function automatic logic [DATA_W:0] youngest_match(
    input logic [ADDR_W-1:0]        rs,
    input logic [PTR_W-1:0]         tail,
    input logic [CNT_W-1:0]         cnt,
    input logic [DEPTH*ENTRY_W-1:0] flat
  );
    logic [DATA_W:0]  res;
    logic [PTR_W-1:0] idx;
    entry_t           e;
    res = '0;
    if (rs != '0) begin
      for (int k = 0; k < DEPTH; k++) begin
        idx = tail - PTR_W'(k + 1);
        e   = flat[idx*ENTRY_W +: ENTRY_W];
        if (!res[DATA_W] && (CNT_W'(k) < cnt) && (e.rd == rs)) res = {1'b1, e.data};
      end
    end
    return res;
  endfunction

  // Source arbitration: src0 wins; full comes from the registered count only.
  assign src0_ready = reset && !full;
  assign src1_ready = reset && !full && !src0_valid;
  assign acc0       = src0_valid && src0_ready;
  assign acc1       = src1_valid && src1_ready;
  assign push_entry = acc0 ? entry_t'{src0_rd, src0_data} : entry_t'{src1_rd, src1_data};
  // Writes to x0 complete the handshake but are never stored.
  assign push       = (acc0 && (src0_rd != '0)) || (acc1 && (src1_rd != '0));

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (drain),
    .full       (full),
    .empty      (empty),
    .head_entry (head_entry),
    .tail_ptr   (tail_ptr),
    .count      (count),
    .entries    (entries)
  );

  // Drain stage: head goes to the write port and pops on the same edge.
  assign drain         = !empty && !wb_hold;
  assign reg_write     = drain;
  assign write_reg_num = drain ? head_entry.rd : '0;
  assign write_data    = drain ? head_entry.data : '0;

  assign {rs1_pending, rs1_fwd} = youngest_match(chk_rs1, tail_ptr, count, entries);
  assign {rs2_pending, rs2_fwd} = youngest_match(chk_rs2, tail_ptr, count, entries);
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Randomized scoreboard bench for regfile_wb_queue against a queue-based model.
module tb_regfile_wb_queue;
  import wb_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              src0_valid = 1'b0;
  logic              src0_ready;
  logic [ADDR_W-1:0] src0_rd = '0;
  logic [DATA_W-1:0] src0_data = '0;
  logic              src1_valid = 1'b0;
  logic              src1_ready;
  logic [ADDR_W-1:0] src1_rd = '0;
  logic [DATA_W-1:0] src1_data = '0;
  logic              wb_hold = 1'b0;
  logic              reg_write;
  logic [ADDR_W-1:0] write_reg_num;
  logic [DATA_W-1:0] write_data;
  logic [ADDR_W-1:0] chk_rs1 = '0;
  logic [ADDR_W-1:0] chk_rs2 = '0;
  logic              rs1_pending;
  logic              rs2_pending;
  logic [DATA_W-1:0] rs1_fwd;
  logic [DATA_W-1:0] rs2_fwd;
  logic [CW-1:0]     count;

  regfile_wb_queue dut (
    .clk           (clk),
    .reset         (reset),
    .src0_valid    (src0_valid),
    .src0_ready    (src0_ready),
    .src0_rd       (src0_rd),
    .src0_data     (src0_data),
    .src1_valid    (src1_valid),
    .src1_ready    (src1_ready),
    .src1_rd       (src1_rd),
    .src1_data     (src1_data),
    .wb_hold       (wb_hold),
    .reg_write     (reg_write),
    .write_reg_num (write_reg_num),
    .write_data    (write_data),
    .chk_rs1       (chk_rs1),
    .chk_rs2       (chk_rs2),
    .rs1_pending   (rs1_pending),
    .rs2_pending   (rs2_pending),
    .rs1_fwd       (rs1_fwd),
    .rs2_fwd       (rs2_fwd),
    .count         (count)
  );

  always #5 clk = ~clk;

  wb_entry_t model_q[$];
  int        checks = 0;
  int        passed = 0;
  logic      a0 = 1'b0;
  logic      a1 = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Youngest queued write to rs, as seen by a reader of the register file.
  task automatic model_lookup(input logic [ADDR_W-1:0] rs, output logic pend, output logic [DATA_W-1:0] fwd);
    pend = 1'b0;
    fwd  = '0;
    if (rs != '0) begin
      foreach (model_q[i]) begin
        if (model_q[i].rd == rs) begin
          pend = 1'b1;
          fwd  = model_q[i].data;
        end
      end
    end
  endtask

  always @(negedge clk) begin : monitor
    int              n;
    logic            full_m;
    logic            p1, p2;
    logic [DATA_W-1:0] f1, f2;
    wb_entry_t       e;
    if (!reset) begin
      check("rst_count", 64'(count), 64'(0));
      check("rst_reg_write", 64'(reg_write), 64'(0));
      check("rst_wdata", 64'(write_data), 64'(0));
      check("rst_ready", 64'({src0_ready, src1_ready}), 64'(0));
      check("rst_pending", 64'({rs1_pending, rs2_pending}), 64'(0));
      check("rst_fwd", 64'(rs1_fwd | rs2_fwd), 64'(0));
    end else begin
      n      = model_q.size();
      full_m = (n == DEPTH);
      check("count", 64'(count), 64'(n));
      check("src0_ready", 64'(src0_ready), 64'(!full_m));
      check("src1_ready", 64'(src1_ready), 64'(!full_m && !src0_valid));
      model_lookup(chk_rs1, p1, f1);
      model_lookup(chk_rs2, p2, f2);
      check("rs1_pending", 64'(rs1_pending), 64'(p1));
      check("rs1_fwd", 64'(rs1_fwd), 64'(f1));
      check("rs2_pending", 64'(rs2_pending), 64'(p2));
      check("rs2_fwd", 64'(rs2_fwd), 64'(f2));
      check("reg_write", 64'(reg_write), 64'((n > 0) && !wb_hold));
      if (reg_write) begin
        if (n == 0) begin
          check("write_from_empty", 64'(1), 64'(0));
        end else begin
          e = model_q.pop_front();
          check("write_reg_num", 64'(write_reg_num), 64'(e.rd));
          check("write_data", 64'(write_data), 64'(e.data));
        end
      end else begin
        check("idle_wnum", 64'(write_reg_num), 64'(0));
        check("idle_wdata", 64'(write_data), 64'(0));
      end
    end
  end

  // Called at posedge+2: drive one cycle, apply the transfer to the model at the edge.
  task automatic run(input int cycles, input int hold_pct, input int vld_pct);
    for (int c = 0; c < cycles; c++) begin
      if (!src0_valid || a0) begin
        src0_valid = ($urandom_range(99) < vld_pct);
        src0_rd    = ADDR_W'($urandom_range(7));
        src0_data  = $urandom;
      end
      if (!src1_valid || a1) begin
        src1_valid = ($urandom_range(99) < vld_pct);
        src1_rd    = ADDR_W'($urandom_range(7));
        src1_data  = $urandom;
      end
      wb_hold = ($urandom_range(99) < hold_pct);
      chk_rs1 = ADDR_W'($urandom_range(7));
      chk_rs2 = ADDR_W'($urandom_range(7));
      a0 = src0_valid && (model_q.size() < DEPTH);
      a1 = src1_valid && (model_q.size() < DEPTH) && !src0_valid;
      @(posedge clk);
      if (a0 && src0_rd != '0) model_q.push_back(wb_entry_t'{src0_rd, src0_data});
      else if (a1 && src1_rd != '0) model_q.push_back(wb_entry_t'{src1_rd, src1_data});
      #2;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    run(400, 30, 90);
    run(12, 100, 100);
    run(300, 0, 100);
    run(300, 50, 60);

    // Queue three entries under hold, then reset asynchronously mid-cycle.
    src1_valid = 1'b0;
    wb_hold    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      src0_valid = 1'b1;
      src0_rd    = ADDR_W'(9 + i);
      src0_data  = 32'h100 + 32'(i);
      a0 = model_q.size() < DEPTH;
      @(posedge clk);
      if (a0) model_q.push_back(wb_entry_t'{src0_rd, src0_data});
      #2;
    end
    src0_valid = 1'b0;
    chk_rs1    = ADDR_W'(9);
    #1 reset = 1'b0;
    model_q.delete();
    #1;
    check("async_rst_count", 64'(count), 64'(0));
    check("async_rst_pending", 64'(rs1_pending), 64'(0));
    check("async_rst_ready", 64'(src0_ready), 64'(0));
    check("async_rst_reg_write", 64'(reg_write), 64'(0));
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    wb_hold = 1'b0;
    a0 = 1'b0;
    a1 = 1'b0;
    run(200, 20, 80);

    src0_valid = 1'b0;
    src1_valid = 1'b0;
    wb_hold    = 1'b0;
    repeat (DEPTH + 2) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
